thermo_ramp_ctrl: RTL and testbench

THERMO_RAMP_CTRL -- requirements
Module: thermo_ramp_ctrl

---
 rtl/thermo_ramp_ctrl.sv | 131 +++++++++++++
 tb/tb_thermo_ramp_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thermo_ramp_ctrl.sv
// thermo_ramp_ctrl: steps a binary code (feeding a thermometer encoder) one LSB at a time
// toward an accepted target, one step every step_div+1 cycles, then pulses done.
// Optional feature: define THERMO_RAMP_SETTLE_EN to add a SETTLE wait of SETTLE_CYCLES
// cycles between reaching the target and the done pulse.
module thermo_ramp_ctrl #(
    parameter int unsigned D_WIDTH       = 4,
    parameter int unsigned DIV_WIDTH     = 8,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tgt_valid,
    output logic                 tgt_ready,
    input  logic [D_WIDTH-1:0]   tgt_code,
    input  logic [DIV_WIDTH-1:0] step_div,
    input  logic                 abort,
    output logic [D_WIDTH-1:0]   code,
    output logic                 busy,
    output logic                 done
);

`ifdef THERMO_RAMP_SETTLE_EN
    typedef enum logic [1:0] {StIdle, StRamp, StSettle, StDone} state_e;
    localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    logic [SetW-1:0] settle_q, settle_d;
`else
    typedef enum logic [1:0] {StIdle, StRamp, StDone} state_e;
`endif

    state_e               state_q, state_d;
    logic [D_WIDTH-1:0]   code_q, code_d;
    logic [D_WIDTH-1:0]   tgt_q, tgt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [D_WIDTH-1:0]   step_code;

    // Next code one LSB toward the target; in RAMP code never equals the target, so no wrap.
    always_comb begin
        step_code = (code_q < tgt_q) ? code_q + D_WIDTH'(1) : code_q - D_WIDTH'(1);
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            code_q   <= '0;
            tgt_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
`ifdef THERMO_RAMP_SETTLE_EN
            settle_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            tgt_q    <= tgt_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
`ifdef THERMO_RAMP_SETTLE_EN
            settle_q <= settle_d;
`endif
        end
    end

    // Next-state logic: accept in IDLE, step in RAMP, optional wait in SETTLE, pulse in DONE.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        tgt_d    = tgt_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
`ifdef THERMO_RAMP_SETTLE_EN
        settle_d = settle_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (tgt_valid) begin
                    tgt_d   = tgt_code;
                    div_d   = step_div;
                    cnt_d   = '0;
                    state_d = (tgt_code == code_q) ? StDone : StRamp;
                end
            end
            StRamp: begin
                // Abort takes priority over a coincident step: code is held.
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_q == div_q) begin
                    cnt_d  = '0;
                    code_d = step_code;
                    if (step_code == tgt_q) begin
`ifdef THERMO_RAMP_SETTLE_EN
                        state_d  = StSettle;
                        settle_d = '0;
`else
                        state_d  = StDone;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
`ifdef THERMO_RAMP_SETTLE_EN
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (settle_q == SetW'(SETTLE_CYCLES - 1)) begin
                    state_d = StDone;
                end else begin
                    settle_d = settle_q + SetW'(1);
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the registered state, so they are glitch-free.
    always_comb begin
        code      = code_q;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        tgt_ready = (state_q == StIdle);
    end

endmodule

// File: tb/tb_thermo_ramp_ctrl.sv
// Self-checking bench for thermo_ramp_ctrl. Expected values come from a closed-form model:
// code after k edges = start +/- min(|t-s|, k/(S+1)); done on the last busy cycle.
// Honours THERMO_RAMP_SETTLE_EN when defined.
module tb_thermo_ramp_ctrl;
    localparam int SETTLE = 16;
    localparam int MAXT   = 400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [3:0] tgt_code = '0;
    logic [7:0] step_div = '0;
    logic       abort = 1'b0;
    logic [3:0] code;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int cur_code = 0;
    logic [6:0] tr_v [MAXT];

    thermo_ramp_ctrl #(
        .D_WIDTH      (4),
        .DIV_WIDTH    (8),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready),
        .tgt_code (tgt_code),
        .step_div (step_div),
        .abort    (abort),
        .code     (code),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Cycles from acceptance until the edge that samples done=1.
    function automatic int model_len(input int s, input int t, input int sdiv);
        int n;
        n = absd(s, t);
        if (n == 0) return 1;
`ifdef THERMO_RAMP_SETTLE_EN
        return n * (sdiv + 1) + SETTLE + 1;
`else
        return n * (sdiv + 1) + 1;
`endif
    endfunction

    function automatic int model_code(input int s, input int t, input int sdiv, input int k);
        int steps;
        steps = k / (sdiv + 1);
        if (steps > absd(s, t)) steps = absd(s, t);
        return (t >= s) ? s + steps : s - steps;
    endfunction

    // Expected {code, busy, done, tgt_ready} k edges after acceptance.
    function automatic logic [6:0] model_vec(input int s, input int t, input int sdiv,
                                             input int k);
        int len;
        logic b;
        len = model_len(s, t, sdiv);
        b = (k < len);
        return {4'(model_code(s, t, sdiv, k)), b, (k == len - 1), ~b};
    endfunction

    // Offer a target, scramble the inputs after acceptance, record ncyc negedge samples.
    task automatic do_ramp(input int t, input int sdiv, input int ncyc);
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_code  = 4'(t);
        step_div  = 8'(sdiv);
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        tgt_code  = 4'($urandom_range(0, 15));
        step_div  = 8'($urandom_range(0, 255));
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            tr_v[k] = {code, busy, done, tgt_ready};
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cur_code = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({code, busy, done, tgt_ready} !== 7'b0000_001)
            $display("FAIL reset_async: got %b expected %b", {code, busy, done, tgt_ready},
                     7'b0000_001);
        if ({code, busy, done, tgt_ready} !== 7'b0000_001) errors++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({code, busy, done, tgt_ready} !== 7'b0000_001) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", {code, busy, done, tgt_ready},
                     7'b0000_001);
        end
        cur_code = 0;
    endtask

    task automatic test_ramp_up();
        int len;
        len = model_len(cur_code, 5, 0);
        do_ramp(5, 0, len + 1);
        for (int k = 0; k <= len; k++) begin
            checks++;
            if (tr_v[k] !== model_vec(cur_code, 5, 0, k)) begin
                errors++;
                $display("FAIL ramp_up k=%0d: got %b expected %b", k, tr_v[k],
                         model_vec(cur_code, 5, 0, k));
            end
        end
        checks++;
        if (tr_v[5][1] !== 1'b1) begin
            errors++;
            $display("FAIL ramp_up_done_at_6: got %b expected 1", tr_v[5][1]);
        end
        cur_code = 5;
    endtask

    task automatic test_ramp_down();
        int len;
        len = model_len(cur_code, 2, 3);
        do_ramp(2, 3, len + 1);
        for (int k = 0; k <= len; k++) begin
            checks++;
            if (tr_v[k] !== model_vec(cur_code, 2, 3, k)) begin
                errors++;
                $display("FAIL ramp_down k=%0d: got %b expected %b", k, tr_v[k],
                         model_vec(cur_code, 2, 3, k));
            end
        end
        checks++;
        if (tr_v[12] !== {4'd2, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ramp_down_done_at_13: got %b expected %b", tr_v[12],
                     {4'd2, 1'b1, 1'b1, 1'b0});
        end
        cur_code = 2;
    endtask

    task automatic test_equal();
        do_ramp(3, 0, model_len(cur_code, 3, 0) + 1);
        cur_code = 3;
        do_ramp(3, 2, 3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (tr_v[k] !== model_vec(3, 3, 2, k)) begin
                errors++;
                $display("FAIL equal k=%0d: got %b expected %b", k, tr_v[k],
                         model_vec(3, 3, 2, k));
            end
        end
    endtask

    // Target offered through DONE must wait for IDLE before being taken.
    task automatic test_back_to_back();
        logic [6:0] exp_bb [5];
        int c;
        c = cur_code;
        exp_bb[0] = {4'(c), 3'b110};
        exp_bb[1] = {4'(c), 3'b001};
        exp_bb[2] = {4'(c), 3'b100};
        exp_bb[3] = {4'(c + 1), 3'b110};
        exp_bb[4] = {4'(c + 1), 3'b001};
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_code  = 4'(c);
        step_div  = 8'd0;
        @(posedge clk);
        #1;
        tgt_code = 4'(c + 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({code, busy, done, tgt_ready} !== exp_bb[k]) begin
                errors++;
                $display("FAIL back_to_back k=%0d: got %b expected %b", k,
                         {code, busy, done, tgt_ready}, exp_bb[k]);
            end
            if (k == 1) begin
                @(posedge clk);
                #1;
                tgt_valid = 1'b0;
            end
        end
        cur_code = c + 1;
    endtask

    task automatic test_async_reset();
        int k7;
        k7 = 7 - cur_code;
        do_ramp(15, 0, k7 + 1);
        checks++;
        if (tr_v[k7][6:3] !== 4'd7) begin
            errors++;
            $display("FAIL async_pre code: got %0d expected 7", tr_v[k7][6:3]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({code, busy, done, tgt_ready} !== 7'b0000_001) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", {code, busy, done, tgt_ready},
                     7'b0000_001);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({code, busy, done, tgt_ready} !== 7'b0000_001) begin
            errors++;
            $display("FAIL async_after: got %b expected %b", {code, busy, done, tgt_ready},
                     7'b0000_001);
        end
        cur_code = 0;
    endtask

    // Abort lands on the 4th step edge of a 0->15 ramp with S=1.
    task automatic test_abort();
        logic [6:0] exp_v;
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_code  = 4'd15;
        step_div  = 8'd1;
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_v = (k <= 7) ? {4'(k / 2), 3'b100} : {4'd3, 3'b001};
            checks++;
            if ({code, busy, done, tgt_ready} !== exp_v) begin
                errors++;
                $display("FAIL abort k=%0d: got %b expected %b", k,
                         {code, busy, done, tgt_ready}, exp_v);
            end
            if (k == 7) abort = 1'b1;
            if (k == 10) abort = 1'b0;
        end
        cur_code = 3;
    endtask

    task automatic test_random();
        int t;
        int sdiv;
        int len;
        for (int i = 0; i < 10; i++) begin
            t    = $urandom_range(0, 15);
            sdiv = $urandom_range(0, 3);
            len  = model_len(cur_code, t, sdiv);
            do_ramp(t, sdiv, len + 1);
            for (int k = 0; k <= len; k++) begin
                checks++;
                if (tr_v[k] !== model_vec(cur_code, t, sdiv, k)) begin
                    errors++;
                    $display("FAIL random i=%0d s=%0d t=%0d S=%0d k=%0d: got %b expected %b",
                             i, cur_code, t, sdiv, k, tr_v[k], model_vec(cur_code, t, sdiv, k));
                end
            end
            cur_code = t;
        end
    endtask

`ifdef THERMO_RAMP_SETTLE_EN
    task automatic test_settle();
        logic [6:0] exp_v;
        do_reset();
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_code  = 4'd2;
        step_div  = 8'd0;
        @(posedge clk);
        #1;
        tgt_code = 4'd9;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp_v = (k <= 18) ? {4'((k < 2) ? k : 2), 1'b1, (k == 18), 1'b0}
                              : {4'd2, 3'b001};
            checks++;
            if ({code, busy, done, tgt_ready} !== exp_v) begin
                errors++;
                $display("FAIL settle k=%0d: got %b expected %b", k,
                         {code, busy, done, tgt_ready}, exp_v);
            end
        end
        tgt_valid = 1'b0;
        cur_code = 2;
    endtask
`endif

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_equal();
        test_back_to_back();
        test_async_reset();
        test_abort();
        test_random();
`ifdef THERMO_RAMP_SETTLE_EN
        test_settle();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
